button_conditioner: RTL and testbench

// - Front end for the six push-buttons of the traffic-light controller; sits directly upstream of the top-level mode/config logic.
// - Synchronises each raw button to clk, debounces it on a 1 ms tick and emits a debounced level plus a one-clk press pulse.
// - The top level consumes only btn_press, never raw pins.
// - Bit map, identical on every bus:
//   [0] changeMode, [1] config, [2] changeLight, [3] increaseTime, [4] decreaseTime, [5] confirm.

---
 rtl/button_conditioner_if.sv | 32 +++
 rtl/button_conditioner.sv | 163 ++++++++++++++++
 tb/tb_button_conditioner.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/button_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner_if
// Description : Button bus between the raw pin side and the conditioned side.
//               slave modport is the conditioner, master is its user/driver.
//               Bit map: [0] changeMode [1] config [2] changeLight
//                        [3] increaseTime [4] decreaseTime [5] confirm
// Revision    : 1.0 - initial release
// ============================================================================
interface button_conditioner_if #(
    parameter int N_BTN = 6
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic             tick;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  tick
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output tick
    );
endinterface
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Two-flop synchroniser, tick-based debouncer and press-pulse
//               generator for the push-buttons of the traffic-light controller.
//               Optional auto-repeat for RPT_MASK bits is enabled by defining
//               the macro AUTO_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int               N_BTN      = 6,
    parameter int               TICK_DIV   = 125000,
    parameter int               DB_TICKS   = 10,
    parameter int               RPT_DELAY  = 500,
    parameter int               RPT_PERIOD = 100,
    parameter logic [N_BTN-1:0] RPT_MASK   = 6'b011000
) (
    input  wire logic           clk,
    input  wire logic           reset,
    button_conditioner_if.slave btn_if
);

`ifdef AUTO_REPEAT_EN
    localparam bit C_RPT_ON = 1'b1;
`else
    localparam bit C_RPT_ON = 1'b0;
`endif

    localparam int C_MAX_A   = (DB_TICKS > RPT_DELAY) ? DB_TICKS : RPT_DELAY;
    localparam int C_CNT_MAX = (C_MAX_A > RPT_PERIOD) ? C_MAX_A : RPT_PERIOD;
    localparam int CW        = $clog2(C_CNT_MAX + 1);
    localparam int PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0] C_PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] C_DB_LAST  = CW'(DB_TICKS - 1);

    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;
    logic [PW-1:0]    pre_q;
    logic             tick_w;
    logic [N_BTN-1:0] level_w;
    logic [N_BTN-1:0] press_w;

    // Two-stage synchroniser for the asynchronous button pins
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_if.btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Shared debounce timebase: wraps after TICK_DIV cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q <= '0;
        end else if (tick_w) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

    assign tick_w = (pre_q == C_PRE_LAST);

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        logic [CW-1:0] db_cnt_q;
        logic [CW-1:0] db_cnt_d;
        logic          level_q;
        logic          level_d;
        logic          rise_w;
        logic          rpt_w;
        logic          press_q;

        // Debounce: count ticks while the synced pin disagrees with the level
        always_comb begin
            db_cnt_d = db_cnt_q;
            level_d  = level_q;
            rise_w   = 1'b0;
            if (sync2_q[i] == level_q) begin
                db_cnt_d = '0;
            end else if (tick_w) begin
                if (db_cnt_q >= C_DB_LAST) begin
                    level_d  = ~level_q;
                    db_cnt_d = '0;
                    rise_w   = ~level_q;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
        end

        // Level, counter and press pulse registers
        always_ff @(posedge clk) begin
            if (reset) begin
                db_cnt_q <= '0;
                level_q  <= 1'b0;
                press_q  <= 1'b0;
            end else begin
                db_cnt_q <= db_cnt_d;
                level_q  <= level_d;
                press_q  <= rise_w | rpt_w;
            end
        end

        if (C_RPT_ON && RPT_MASK[i]) begin : g_rpt
            localparam logic [CW-1:0] C_DLY_LAST = CW'(RPT_DELAY - 1);
            localparam logic [CW-1:0] C_PER_LAST = CW'(RPT_PERIOD - 1);

            logic [CW-1:0] hold_q;
            logic [CW-1:0] hold_d;
            logic          phase_q;
            logic          phase_d;
            logic          fire_w;

            // Hold timer: first repeat after RPT_DELAY ticks, then every
            // RPT_PERIOD ticks; only counts while the level stays pressed
            always_comb begin
                hold_d  = hold_q;
                phase_d = phase_q;
                fire_w  = 1'b0;
                if (!(level_q && level_d)) begin
                    hold_d  = '0;
                    phase_d = 1'b0;
                end else if (tick_w) begin
                    if (hold_q >= (phase_q ? C_PER_LAST : C_DLY_LAST)) begin
                        fire_w  = 1'b1;
                        hold_d  = '0;
                        phase_d = 1'b1;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end

            // Hold timer registers
            always_ff @(posedge clk) begin
                if (reset) begin
                    hold_q  <= '0;
                    phase_q <= 1'b0;
                end else begin
                    hold_q  <= hold_d;
                    phase_q <= phase_d;
                end
            end

            assign rpt_w = fire_w;
        end else begin : g_norpt
            assign rpt_w = 1'b0;
        end

        assign level_w[i] = level_q;
        assign press_w[i] = press_q;
    end

    assign btn_if.btn_level = level_w;
    assign btn_if.btn_press = press_w;
    assign btn_if.tick      = tick_w;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_conditioner
// Description : Self-checking bench for button_conditioner with a behavioural
//               reference model, directed scenarios and random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_button_conditioner;
    localparam int          TD   = 4;
    localparam int          DB   = 3;
    localparam int          RD   = 5;
    localparam int          RP   = 2;
    localparam logic [5:0]  MASK = 6'b011000;
`ifdef AUTO_REPEAT_EN
    localparam bit RPT_ON = 1'b1;
`else
    localparam bit RPT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    button_conditioner_if #(.N_BTN(6)) bus ();

    button_conditioner #(
        .N_BTN(6), .TICK_DIV(TD), .DB_TICKS(DB),
        .RPT_DELAY(RD), .RPT_PERIOD(RP), .RPT_MASK(MASK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .btn_if(bus.slave)
    );

    int tests = 0;
    int fails = 0;
    int gcyc  = 0;
    int pcnt[6];
    int first_pulse[6];
    int track = 4;
    int pq[$];

    // reference model state
    int         m_cyc;
    logic [5:0] m_r1, m_r2, m_lvl, m_press;
    logic       m_tick;
    int         m_run[6];
    int         m_hold[6];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge of the specified behaviour, from the inputs present at the edge
    task automatic model_edge();
        logic [5:0] s, old;
        bit tk;
        m_press = '0;
        if (reset) begin
            m_cyc = 0; m_r1 = '0; m_r2 = '0; m_lvl = '0; m_tick = 1'b0;
            for (int i = 0; i < 6; i++) begin m_run[i] = 0; m_hold[i] = 0; end
        end else begin
            s   = m_r2;
            old = m_lvl;
            tk  = ((m_cyc % TD) == TD - 1);
            for (int i = 0; i < 6; i++) begin
                if (s[i] == m_lvl[i]) m_run[i] = 0;
                else if (tk) begin
                    m_run[i]++;
                    if (m_run[i] >= DB) begin
                        m_lvl[i] = ~m_lvl[i];
                        m_run[i] = 0;
                        if (m_lvl[i]) m_press[i] = 1'b1;
                    end
                end
                if (RPT_ON && MASK[i]) begin
                    if (old[i] && m_lvl[i]) begin
                        if (tk) begin
                            m_hold[i]++;
                            if (m_hold[i] == RD || (m_hold[i] > RD && ((m_hold[i] - RD) % RP) == 0))
                                m_press[i] = 1'b1;
                        end
                    end else m_hold[i] = 0;
                end
            end
            m_r2 = m_r1;
            m_r1 = bus.btn_raw;
            m_cyc++;
            m_tick = ((m_cyc % TD) == TD - 1);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        gcyc++;
        #1;
        chk("level", {26'd0, bus.btn_level}, {26'd0, m_lvl});
        chk("press", {26'd0, bus.btn_press}, {26'd0, m_press});
        chk("tick",  {31'd0, bus.tick},      {31'd0, m_tick});
        for (int i = 0; i < 6; i++) begin
            if (bus.btn_press[i] === 1'b1) begin
                pcnt[i]++;
                if (first_pulse[i] < 0) first_pulse[i] = gcyc;
                if (i == track) pq.push_back(gcyc);
            end
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 6; i++) begin pcnt[i] = 0; first_pulse[i] = -1; end
        pq.delete();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    int base;
    int others;

    initial begin
        bus.btn_raw = 6'h3F;
        reset = 1'b1;
        clear_stats();

        // reset held with all buttons pressed
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_level", {26'd0, bus.btn_level}, 32'd0);
            chk("rst_press", {26'd0, bus.btn_press}, 32'd0);
            chk("rst_tick",  {31'd0, bus.tick},      32'd0);
        end
        reset = 1'b0;
        clear_stats();
        run(20);
        chk("pwr_level", {26'd0, bus.btn_level}, 32'h3F);
        for (int i = 0; i < 6; i++) chk("pwr_pulses", pcnt[i], 1);
        bus.btn_raw = '0;
        run(24);
        chk("pwr_release", {26'd0, bus.btn_level}, 32'd0);

        // clean press on bit 0
        clear_stats();
        bus.btn_raw[0] = 1'b1;
        base = gcyc;
        run(40);
        chk("clean_count", pcnt[0], 1);
        chk("clean_latency_11_15",
            32'((first_pulse[0] - base >= 11) && (first_pulse[0] - base <= 15)), 32'd1);
        chk("clean_level", {31'd0, bus.btn_level[0]}, 32'd1);
        others = 0;
        for (int i = 1; i < 6; i++) others += pcnt[i];
        chk("clean_others", others, 0);
        bus.btn_raw[0] = 1'b0;
        run(24);

        // bounce on bit 2
        clear_stats();
        for (int k = 0; k < 4; k++) begin
            bus.btn_raw[2] = 1'b1; run(5);
            bus.btn_raw[2] = 1'b0; run(3);
        end
        run(20);
        chk("bounce_count", pcnt[2], 0);
        chk("bounce_level", {31'd0, bus.btn_level[2]}, 32'd0);

        // simultaneous press on bits 1 and 5
        clear_stats();
        bus.btn_raw[1] = 1'b1;
        bus.btn_raw[5] = 1'b1;
        run(24);
        chk("simul_count1", pcnt[1], 1);
        chk("simul_count5", pcnt[5], 1);
        chk("simul_same_clk", first_pulse[1], first_pulse[5]);
        clear_stats();
        bus.btn_raw = '0;
        run(24);
        chk("simul_release_pulses", pcnt[1] + pcnt[5], 0);
        chk("simul_release_level", {26'd0, bus.btn_level}, 32'd0);

        // reset mid-debounce on bit 3
        clear_stats();
        bus.btn_raw[3] = 1'b1;
        run(6);
        chk("midrst_pre", pcnt[3], 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        clear_stats();
        run(20);
        chk("midrst_post", pcnt[3], 1);
        chk("midrst_level", {31'd0, bus.btn_level[3]}, 32'd1);
        bus.btn_raw[3] = 1'b0;
        run(30);

        // long hold on bit 4
        clear_stats();
        track = 4;
        bus.btn_raw[4] = 1'b1;
        run(60);
        bus.btn_raw[4] = 1'b0;
        run(24);
        if (RPT_ON) begin
            chk("rpt_count_ge4", 32'(pq.size() >= 4), 32'd1);
            if (pq.size() >= 4) begin
                chk("rpt_first_gap", pq[1] - pq[0], 20);
                for (int k = 2; k < pq.size(); k++) chk("rpt_gap", pq[k] - pq[k-1], 8);
            end
        end else begin
            chk("norpt_count", pcnt[4], 1);
        end

        // long hold on bit 0 never repeats
        clear_stats();
        bus.btn_raw[0] = 1'b1;
        run(60);
        bus.btn_raw[0] = 1'b0;
        run(24);
        chk("hold0_count", pcnt[0], 1);

        // random stimulus against the model
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(5) == 0) bus.btn_raw[$urandom_range(5)] ^= 1'b1;
            reset = ($urandom_range(149) == 0);
            step();
        end
        reset = 1'b0;
        run(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
